control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle sequencing FSM for the K&S processor. It sits beside `data_path` and takes that block's `decoded_instruction` and four flag outputs. It drives every datapath control strobe plus the RAM write enable, so fetch, decode, execute and PC update happen in order, one instruction at a time. It also keeps a retired-instruction counter for bring-up and performance checks.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `decoded_instruction`  in  `decoded_instruction_type`  current instruction class from the datapath decoder.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  in  1 each  registered datapath flags.
- `branch`  out  1  select branch target for the PC load.
- `pc_enable`  out  1  PC update strobe.
- `ir_enable`  out  1  instruction register load.
- `addr_sel`  out  1  RAM address select: 0 = PC, 1 = instruction address field.
- `c_sel`  out  1  register write source: 0 = ALU, 1 = `data_in`.
- `operation`  out  2  ALU opcode: 00 ADD, 01 AND, 10 OR, 11 SUB.
- `write_reg_enable`  out  1  register file write.
- `flags_reg_enable`  out  1  flag register update.
- `ram_write_enable`  out  1  RAM write strobe.
- `halt`  out  1  core halted.
- `instr_count`  out  `CNT_W`  retired instructions, saturating.

## Operation
- States: `S_FETCH`, `S_DECODE`, `S_LOAD`, `S_STORE`, `S_ALU`, `S_BRANCH`, `S_NEXT`, `S_HALT`.
- Outputs are Moore-style, decoded from the state. The only exception is `branch`/`pc_enable` in `S_BRANCH`, which also depend on the flags.
- Any output not listed for a state is 0.
- `S_FETCH`: `addr_sel`=0, `ir_enable`=1. Next state is `S_DECODE`.
- `S_DECODE`: no strobes. This cycle lets the datapath's registered operand buses settle. Next state by class:
  - I_LOAD → `S_LOAD`
  - I_STORE → `S_STORE`
  - I_MOVE, I_ADD, I_SUB, I_AND, I_OR → `S_ALU`
  - any branch class → `S_BRANCH`
  - I_HALT → `S_HALT`
  - I_NOP and any unknown class → `S_NEXT`
- `S_LOAD`: `addr_sel`=1, `c_sel`=1, `write_reg_enable`=1. Next state is `S_NEXT`.
- `S_STORE`: `addr_sel`=1, `ram_write_enable`=1. Next state is `S_NEXT`.
- `S_ALU`: `c_sel`=0, `write_reg_enable`=1.
  - `operation` per class: ADD 00, AND 01, OR 10, SUB 11, MOVE 10 (OR of a register with itself).
  - `flags_reg_enable`=1 for all classes except MOVE.
  - Next state is `S_NEXT`.
- `S_BRANCH`: taken condition per class:
  - BRANCH: always taken.
  - BZERO: `zero_op`. BNZERO: !`zero_op`.
  - BNEG: `neg_op`. BNNEG: !`neg_op`.
  - BOV: `unsigned_overflow`. BNOV: !`unsigned_overflow`.
  - If taken: `pc_enable`=1, `branch`=1, next state `S_FETCH`.
  - If not taken: next state `S_NEXT`.
- `S_NEXT`: `pc_enable`=1, `branch`=0. Next state is `S_FETCH`.
- `S_HALT`: `halt`=1. The FSM stays here until `rst_n` is asserted; no strobes are issued.
- `instr_count` increments by 1 on each cycle that leaves `S_NEXT`, leaves a taken `S_BRANCH`, or enters `S_HALT`. It saturates at all-ones and never wraps.
- `signed_overflow` is accepted as an input but unused; no branch class tests it.

## Timing
- Reset:
  - state = `S_FETCH`, `instr_count` = 0.
  - While `rst_n`=0, all outputs are forced to 0, including the `S_FETCH` strobes.
- Reset asserted mid-instruction: immediate abort. No partial register or RAM write happens after assertion.
- After deassertion, the first `ir_enable` pulse is in the first cycle.
- Cycle counts per instruction:
  - NOP: 3
  - LOAD, STORE, ALU/MOVE: 4
  - taken branch: 3
  - not-taken branch: 4
- Flags sampled in `S_BRANCH` are the registered values from the most recent flag-updating ALU instruction.
- RAM read data is combinational from `ram_addr` and valid in the same cycle. The RAM write occurs on the clock edge that ends `S_STORE`.

## Structure
- `k_and_s_pkg` holds `ctrl_state_t` (enum of the eight states) and the ALU opcode constants `ALU_ADD`, `ALU_AND`, `ALU_OR`, `ALU_SUB`.
- `decoded_instruction_type` is reused from `k_and_s_pkg`.
- Single module, no sub-modules. Branch evaluation is a local function.
- Top level `k_and_s` instantiates `data_path` and `control_unit`.

## Test plan
- Reset held, then released; RAM[0]=NOP, RAM[1]=HALT → `ir_enable` pulses in cycles 0 and 3, `halt`=1 from cycle 5, `instr_count`=2.
- LOAD R1,[5] with RAM[5]=16'h00FF, then ADD R2,R1,R1 → `write_reg_enable` in cycle 2 with `c_sel`=1; ALU cycle has `operation`=00 and `flags_reg_enable`=1; R2=16'h01FE.
- SUB giving 0, then BZERO 12 → `branch`=1, `pc_enable`=1 in `S_BRANCH`, next fetch address 12. Repeat with BNZERO: not taken, PC+1.
- MOVE R3,R0 → `operation`=10, `flags_reg_enable`=0, flags unchanged.
- `rst_n` asserted during `S_STORE` → `ram_write_enable` drops immediately and state returns to `S_FETCH`.
- Force `instr_count` near all-ones (`CNT_W`=4 build), run 20 NOPs → count holds at 15.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared K&S processor types: decoded instruction classes, control FSM states
// and ALU opcode constants.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_STORE  = 3'd3,
        S_ALU    = 3'd4,
        S_BRANCH = 3'd5,
        S_NEXT   = 3'd6,
        S_HALT   = 3'd7
    } ctrl_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the K&S core: drives the datapath strobes and RAM
// write enable one instruction at a time and counts retired instructions.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    function automatic logic branch_taken(input decoded_instruction_type cls,
                                          input logic z, input logic n,
                                          input logic uov);
        case (cls)
            I_BRANCH: return 1'b1;
            I_BZERO:  return z;
            I_BNZERO: return !z;
            I_BNEG:   return n;
            I_BNNEG:  return !n;
            I_BOV:    return uov;
            I_BNOV:   return !uov;
            default:  return 1'b0;
        endcase
    endfunction

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             taken;
    logic             retire;
    logic             branch_s, pc_s, ir_s, addr_s, csel_s;
    logic [1:0]       op_s;
    logic             wre_s, fre_s, ramwe_s, halt_s;
    logic             signed_overflow_unused;

    assign signed_overflow_unused = signed_overflow;
    assign taken = branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow);

    always_comb begin
        state_d  = state_q;
        branch_s = 1'b0;
        pc_s     = 1'b0;
        ir_s     = 1'b0;
        addr_s   = 1'b0;
        csel_s   = 1'b0;
        op_s     = ALU_ADD;
        wre_s    = 1'b0;
        fre_s    = 1'b0;
        ramwe_s  = 1'b0;
        halt_s   = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_s    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:                             state_d = S_LOAD;
                    I_STORE:                            state_d = S_STORE;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:  state_d = S_ALU;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                    I_BNNEG, I_BOV, I_BNOV:             state_d = S_BRANCH;
                    I_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default:                            state_d = S_NEXT;
                endcase
            end
            S_LOAD: begin
                addr_s  = 1'b1;
                csel_s  = 1'b1;
                wre_s   = 1'b1;
                state_d = S_NEXT;
            end
            S_STORE: begin
                addr_s  = 1'b1;
                ramwe_s = 1'b1;
                state_d = S_NEXT;
            end
            S_ALU: begin
                wre_s = 1'b1;
                fre_s = (decoded_instruction != I_MOVE);
                // MOVE is an OR of the source register with itself.
                case (decoded_instruction)
                    I_AND:        op_s = ALU_AND;
                    I_OR, I_MOVE: op_s = ALU_OR;
                    I_SUB:        op_s = ALU_SUB;
                    default:      op_s = ALU_ADD;
                endcase
                state_d = S_NEXT;
            end
            S_BRANCH: begin
                if (taken) begin
                    pc_s     = 1'b1;
                    branch_s = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                pc_s    = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halt_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign count_d = (retire && !(&count_q)) ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Gate with rst_n so reset kills strobes (including FETCH's) the moment it asserts.
    assign branch           = rst_n & branch_s;
    assign pc_enable        = rst_n & pc_s;
    assign ir_enable        = rst_n & ir_s;
    assign addr_sel         = rst_n & addr_s;
    assign c_sel            = rst_n & csel_s;
    assign operation        = rst_n ? op_s : 2'b00;
    assign write_reg_enable = rst_n & wre_s;
    assign flags_reg_enable = rst_n & fre_s;
    assign ram_write_enable = rst_n & ramwe_s;
    assign halt             = rst_n & halt_s;
    assign instr_count      = rst_n ? count_q : '0;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each directed
// instruction into its expected per-cycle strobe pattern and retire points.
module tb_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        decoded_instruction_type cls;
        logic z;
        logic n;
        logic u;
    } step_t;

    // Output vector bits: branch pc ir addr c_sel op[1:0] wre fre ramwe halt
    localparam logic [10:0] V_FETCH = 11'b00100000000;
    localparam logic [10:0] V_LOAD  = 11'b00011001000;
    localparam logic [10:0] V_STORE = 11'b00010000010;
    localparam logic [10:0] V_NEXT  = 11'b01000000000;
    localparam logic [10:0] V_TAKEN = 11'b11000000000;
    localparam logic [10:0] V_HALT  = 11'b00000000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    decoded_instruction_type instr;
    logic zero, neg, uov, sov;

    logic        branch, pcEn, irEn, addrSel, cSel, wre, fre, ramWe, haltO;
    logic [1:0]  op;
    logic [15:0] count;
    logic        sBranch, sPcEn, sIrEn, sAddrSel, sCSel, sWre, sFre, sRamWe, sHalt;
    logic [1:0]  sOp;
    logic [3:0]  countSat;
    logic [10:0] outVec, satVec;

    assign outVec = {branch, pcEn, irEn, addrSel, cSel, op, wre, fre, ramWe, haltO};
    assign satVec = {sBranch, sPcEn, sIrEn, sAddrSel, sCSel, sOp, sWre, sFre, sRamWe, sHalt};

    control_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero), .neg_op(neg), .unsigned_overflow(uov), .signed_overflow(sov),
        .branch(branch), .pc_enable(pcEn), .ir_enable(irEn), .addr_sel(addrSel),
        .c_sel(cSel), .operation(op), .write_reg_enable(wre), .flags_reg_enable(fre),
        .ram_write_enable(ramWe), .halt(haltO), .instr_count(count)
    );

    control_unit #(.CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero), .neg_op(neg), .unsigned_overflow(uov), .signed_overflow(sov),
        .branch(sBranch), .pc_enable(sPcEn), .ir_enable(sIrEn), .addr_sel(sAddrSel),
        .c_sel(sCSel), .operation(sOp), .write_reg_enable(sWre), .flags_reg_enable(sFre),
        .ram_write_enable(sRamWe), .halt(sHalt), .instr_count(countSat)
    );

    int errors = 0;
    int checks = 0;
    int expCount;
    step_t       prog[$];
    step_t       inQ[$];
    logic [10:0] expQ[$];
    bit          retQ[$];
    logic [10:0] trace[0:511];
    int          traceCount[0:511];
    int          traceSat[0:511];
    int          traceLen;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic step_t mk(input decoded_instruction_type c, input logic z,
                                 input logic n, input logic u);
        step_t s;
        s.cls = c; s.z = z; s.n = n; s.u = u;
        return s;
    endfunction

    function automatic bit takenFor(input step_t s);
        case (s.cls)
            I_BRANCH: return 1'b1;
            I_BZERO:  return s.z;
            I_BNZERO: return !s.z;
            I_BNEG:   return s.n;
            I_BNNEG:  return !s.n;
            I_BOV:    return s.u;
            I_BNOV:   return !s.u;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [10:0] aluVec(input decoded_instruction_type c);
        logic [1:0] o;
        case (c)
            I_ADD:   o = 2'b00;
            I_AND:   o = 2'b01;
            I_SUB:   o = 2'b11;
            default: o = 2'b10;
        endcase
        return {5'b00000, o, 1'b1, (c != I_MOVE), 2'b00};
    endfunction

    function automatic void pushCycle(input logic [10:0] v, input bit r, input step_t s);
        expQ.push_back(v);
        retQ.push_back(r);
        inQ.push_back(s);
    endfunction

    // Expand the program into one expected vector per clock cycle.
    function automatic void expandProgram(input int haltCycles);
        expQ.delete(); retQ.delete(); inQ.delete();
        foreach (prog[k]) begin
            step_t s = prog[k];
            pushCycle(V_FETCH, 1'b0, s);
            pushCycle(11'b0, s.cls == I_HALT, s);
            if (s.cls == I_HALT) begin
                for (int h = 0; h < haltCycles; h++) pushCycle(V_HALT, 1'b0, s);
                break;
            end
            case (s.cls)
                I_LOAD:  begin pushCycle(V_LOAD, 1'b0, s);  pushCycle(V_NEXT, 1'b1, s); end
                I_STORE: begin pushCycle(V_STORE, 1'b0, s); pushCycle(V_NEXT, 1'b1, s); end
                I_MOVE, I_ADD, I_SUB, I_AND, I_OR: begin
                    pushCycle(aluVec(s.cls), 1'b0, s);
                    pushCycle(V_NEXT, 1'b1, s);
                end
                I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                    if (takenFor(s)) pushCycle(V_TAKEN, 1'b1, s);
                    else begin
                        pushCycle(11'b0, 1'b0, s);
                        pushCycle(V_NEXT, 1'b1, s);
                    end
                end
                default: pushCycle(V_NEXT, 1'b1, s);
            endcase
        end
    endfunction

    task automatic resetDut();
        rst_n = 1'b0;
        instr = I_NOP;
        zero = 1'b0; neg = 1'b0; uov = 1'b0; sov = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("reset outputs", outVec, 11'b0);
            checkOutput("reset sat outputs", satVec, 11'b0);
            checkOutput("reset count", count, 0);
            checkOutput("reset sat count", countSat, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        expCount = 0;
    endtask

    // Called #1 after a rising edge with reset just released.
    task automatic applyStimulus(input int haltCycles);
        expandProgram(haltCycles);
        traceLen = expQ.size();
        for (int i = 0; i < expQ.size(); i++) begin
            instr = inQ[i].cls;
            zero  = inQ[i].z;
            neg   = inQ[i].n;
            uov   = inQ[i].u;
            sov   = i[0];
            @(negedge clk);
            trace[i]      = outVec;
            traceCount[i] = int'(count);
            traceSat[i]   = int'(countSat);
            checkOutput($sformatf("outputs cyc%0d", i), outVec, expQ[i]);
            checkOutput($sformatf("sat outputs cyc%0d", i), satVec, expQ[i]);
            checkOutput($sformatf("count cyc%0d", i), count, expCount);
            checkOutput($sformatf("sat count cyc%0d", i), countSat,
                        (expCount > 15) ? 15 : expCount);
            @(posedge clk);
            #1;
            if (retQ[i]) expCount++;
        end
    endtask

    initial begin
        resetDut();

        // NOP then HALT
        prog.delete();
        prog.push_back(mk(I_NOP, 0, 0, 0));
        prog.push_back(mk(I_HALT, 0, 0, 0));
        applyStimulus(3);
        checkOutput("lit ir cyc0", trace[0][8], 1);
        checkOutput("lit ir cyc3", trace[3][8], 1);
        checkOutput("lit no ir cyc2", trace[2][8], 0);
        checkOutput("lit halt cyc5", trace[5][0], 1);
        checkOutput("lit halt count", traceCount[7], 2);

        // Loads, ALU ops and every branch class both ways
        resetDut();
        prog.delete();
        prog.push_back(mk(I_LOAD, 0, 0, 0));
        prog.push_back(mk(I_ADD, 0, 0, 0));
        prog.push_back(mk(I_SUB, 0, 0, 0));
        prog.push_back(mk(I_BZERO, 1, 0, 0));
        prog.push_back(mk(I_BNZERO, 1, 0, 0));
        prog.push_back(mk(I_MOVE, 1, 0, 0));
        prog.push_back(mk(I_AND, 1, 0, 0));
        prog.push_back(mk(I_OR, 0, 0, 0));
        prog.push_back(mk(I_BRANCH, 0, 0, 0));
        prog.push_back(mk(I_BNEG, 0, 1, 0));
        prog.push_back(mk(I_BNNEG, 0, 1, 0));
        prog.push_back(mk(I_BOV, 0, 0, 1));
        prog.push_back(mk(I_BNOV, 0, 0, 1));
        prog.push_back(mk(I_BZERO, 0, 0, 0));
        prog.push_back(mk(I_BNEG, 0, 0, 0));
        prog.push_back(mk(I_BNNEG, 0, 0, 0));
        prog.push_back(mk(I_BOV, 0, 0, 0));
        prog.push_back(mk(I_BNOV, 0, 0, 0));
        prog.push_back(mk(I_STORE, 0, 0, 0));
        prog.push_back(mk(I_NOP, 0, 0, 0));
        prog.push_back(mk(I_HALT, 0, 0, 0));
        applyStimulus(2);
        checkOutput("lit load cyc2", trace[2], 11'b00011001000);
        checkOutput("lit add cyc6", trace[6], 11'b00000001100);
        checkOutput("lit sub cyc10", trace[10], 11'b00000111100);
        checkOutput("lit bzero taken cyc14", trace[14], 11'b11000000000);
        checkOutput("lit bnzero idle cyc17", trace[17], 11'b0);
        checkOutput("lit bnzero next cyc18", trace[18], 11'b01000000000);
        checkOutput("lit move cyc21", trace[21], 11'b00000101000);
        checkOutput("lit final count", traceCount[traceLen-1], 21);
        checkOutput("lit final sat count", traceSat[traceLen-1], 15);

        // Reset asserted during the STORE cycle
        resetDut();
        instr = I_STORE;
        @(negedge clk);
        checkOutput("store fetch", outVec, V_FETCH);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("store decode", outVec, 11'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("store ram we", ramWe, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort ram we", ramWe, 0);
        checkOutput("abort outputs", outVec, 11'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort refetch", outVec, 11'b00100000000);
        @(posedge clk); #1;

        // Counter saturation in the narrow build
        resetDut();
        prog.delete();
        for (int k = 0; k < 20; k++) prog.push_back(mk(I_NOP, 0, 0, 0));
        prog.push_back(mk(I_HALT, 0, 0, 0));
        applyStimulus(2);
        checkOutput("lit nop sat count", traceSat[traceLen-1], 15);
        checkOutput("lit nop count", traceCount[traceLen-1], 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
